// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router write-path controller.
//   state_e      : packet state machine encoding (8 states, 3 bits)
//   ADDR_INVALID : header address that selects no output port
//   NUM_PORTS    : number of output FIFOs
//   port_bit     : pick one per-port flag by a 2-bit address (0 for the
//                  invalid address, so no out-of-range indexing occurs)
//   port_onehot  : one-hot decode of a 2-bit address (0 for invalid)
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                      input logic [1:0]           a);
        logic r;
        case (a)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] a);
        logic [NUM_PORTS-1:0] r;
        case (a)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_timeout.sv
// ---------------------------------------------------------------------------
// router_timeout
// Read-timeout watchdog for one output port. Counts cycles during which the
// port holds valid data that nobody reads; after TIMEOUT such cycles it emits
// a registered one-cycle soft_reset pulse and starts counting again.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   valid_i      : output port has data available
//   read_enb_i   : destination is reading this port
//   soft_reset_o : one-cycle flush pulse for this port's FIFO
// ---------------------------------------------------------------------------
module router_timeout #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    input  logic read_enb_i,
    output logic soft_reset_o
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        if (!valid_i || read_enb_i) begin
            // Any read, or an empty port, restarts the measurement.
            count_d = '0;
        end else if (count_q == LAST_COUNT) begin
            // TIMEOUT consecutive unread cycles: fire and start over.
            count_d = '0;
            pulse_d = 1'b1;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// ---------------------------------------------------------------------------
// router_ctrl
// Packet-sequencing controller for the 1x3 router write path.
//   Inputs : clk, reset (sync, active-high), pkt_valid, data_in[1:0] (header
//            address), parity_done, low_pkt_valid, fifo_empty[2:0],
//            fifo_full[2:0], read_enb[2:0]
//   Outputs: state strobes (detect_add, lfd_state, ld_state, laf_state,
//            full_state, rst_int_reg), write_enb_reg, busy, write_enb[2:0]
//            one-hot FIFO write enable, fifo_full_sel, valid_out[2:0],
//            soft_reset[2:0] read-timeout flush pulses
// The state strobes are decoded combinationally from the state register.
// ---------------------------------------------------------------------------
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5     // 2**CW must be >= TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [2:0] write_enb,
    input  logic [2:0] fifo_full,
    output logic       fifo_full_sel,
    output logic [2:0] valid_out,
    output logic [2:0] soft_reset
);

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    // ------------------------------------------------------------------
    // Per-port flags and timeout watchdogs
    // ------------------------------------------------------------------
    assign valid_out = ~fifo_empty;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_timeout
        router_timeout #(
            .TIMEOUT (TIMEOUT),
            .CW      (CW)
        ) u_timeout (
            .clk          (clk),
            .reset        (reset),
            .valid_i      (valid_out[gi]),
            .read_enb_i   (read_enb[gi]),
            .soft_reset_o (soft_reset[gi])
        );
    end

    // Full flag of the port the current packet is heading to. The invalid
    // address maps to "not full" so a dropped header never stalls anything.
    assign fifo_full_sel = port_bit(fifo_full, addr_q);

    // ------------------------------------------------------------------
    // Address latch: captured on every header byte, including the invalid
    // address, so fifo_full_sel and write_enb track the last header seen.
    // ------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        if (detect_add && pkt_valid) begin
            addr_d = data_in;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                // Header decisions use data_in directly; addr_q is only
                // loaded on this same edge.
                if (pkt_valid && data_in != ADDR_INVALID) begin
                    if (port_bit(fifo_empty, data_in)) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (port_bit(fifo_empty, addr_q)) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                // A full FIFO wins over end-of-packet.
                if (fifo_full_sel) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full_sel) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_d = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (fifo_full_sel) begin
                    state_d = FIFO_FULL_STATE;
                end else begin
                    state_d = DECODE_ADDRESS;
                end
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A timeout flush of the active port abandons the packet in flight.
        if (state_q != DECODE_ADDRESS && port_bit(soft_reset, addr_q)) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) ||
                           (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    // The source may only push bytes while decoding a header or streaming
    // payload; every other state stalls it.
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

    assign write_enb     = write_enb_reg ? port_onehot(addr_q) : 3'b000;

endmodule

// File: tb/tb_router_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_ctrl
// Directed bench for router_ctrl: a table of per-cycle input/expected-output
// records for the packet state machine, plus hand-written sequences for the
// read-timeout watchdog and the timeout-abort of a packet in flight.
// ---------------------------------------------------------------------------
module tb_router_ctrl;

    typedef enum int {S_D, S_W, S_F, S_L, S_P, S_C, S_U, S_A} st_e;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       pd;
        logic       lpv;
        logic [2:0] fe;
        logic [2:0] ff;
        st_e        st;
        logic [2:0] we;
        logic       sel;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, fifo_full_sel;
    logic [2:0] write_enb, valid_out, soft_reset;

    int tests;
    int fails;
    vec_t vecs[$];

    router_ctrl #(.TIMEOUT(30), .CW(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_empty    (fifo_empty),
        .read_enb      (read_enb),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .fifo_full_sel (fifo_full_sel),
        .valid_out     (valid_out),
        .soft_reset    (soft_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {detect,lfd,ld,laf,full,rst_int,write_enb_reg,busy} per state.
    function automatic logic [7:0] exp_ctl(input st_e s);
        return {s == S_D, s == S_F, s == S_L, s == S_A, s == S_U, s == S_C,
                (s == S_L) || (s == S_P) || (s == S_A),
                !((s == S_D) || (s == S_L))};
    endfunction

    function automatic logic [7:0] act_ctl();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    function automatic void add(input logic pv, input logic [1:0] din,
                                input logic pd, input logic lpv,
                                input logic [2:0] fe, input logic [2:0] ff,
                                input st_e st, input logic [2:0] we,
                                input logic sel);
        vec_t v;
        v.pv = pv; v.din = din; v.pd = pd; v.lpv = lpv;
        v.fe = fe; v.ff = ff; v.st = st; v.we = we; v.sel = sel;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        pkt_valid = 1'b1;
        data_in = 2'd1;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_empty = 3'b111;
        fifo_full = 3'b000;
        read_enb = 3'b000;

        // ---------------- vector table ----------------
        // A: addr 1, three payload bytes, parity
        add(1, 1, 0, 0, 3'b111, 3'b000, S_F, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_P, 3'b010, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_C, 3'b000, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_D, 3'b000, 0);
        // B: addr 1, FIFO 1 full for 4 cycles during payload
        add(1, 1, 0, 0, 3'b111, 3'b000, S_F, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(1, 0, 0, 0, 3'b111, 3'b010, S_U, 3'b000, 1);
        add(1, 0, 0, 0, 3'b111, 3'b010, S_U, 3'b000, 1);
        add(1, 0, 0, 0, 3'b111, 3'b010, S_U, 3'b000, 1);
        add(1, 0, 0, 0, 3'b111, 3'b010, S_U, 3'b000, 1);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_A, 3'b010, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b010, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_P, 3'b010, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_C, 3'b000, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_D, 3'b000, 0);
        // C: addr 2 while FIFO 2 not empty -> wait
        add(1, 2, 0, 0, 3'b011, 3'b000, S_W, 3'b000, 0);
        add(1, 0, 0, 0, 3'b011, 3'b000, S_W, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_F, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b100, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_P, 3'b100, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_C, 3'b000, 0);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_D, 3'b000, 0);
        // D: invalid addr 3 is dropped; full flags ignored for it
        add(1, 3, 0, 0, 3'b111, 3'b000, S_D, 3'b000, 0);
        add(1, 3, 0, 0, 3'b111, 3'b111, S_D, 3'b000, 0);
        add(0, 0, 0, 0, 3'b111, 3'b111, S_D, 3'b000, 0);
        // E: addr 0, LAF exits, full-over-end priority, CPE -> FULL
        add(1, 0, 0, 0, 3'b111, 3'b000, S_F, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b001, 0);
        add(1, 0, 0, 0, 3'b111, 3'b001, S_U, 3'b000, 1);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_A, 3'b001, 0);
        add(1, 0, 1, 0, 3'b111, 3'b000, S_D, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_F, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b000, S_L, 3'b001, 0);
        add(0, 0, 0, 0, 3'b111, 3'b001, S_U, 3'b000, 1);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_A, 3'b001, 0);
        add(0, 0, 0, 1, 3'b111, 3'b000, S_P, 3'b001, 0);
        add(0, 0, 0, 0, 3'b111, 3'b001, S_C, 3'b000, 1);
        add(0, 0, 0, 0, 3'b111, 3'b001, S_U, 3'b000, 1);
        add(0, 0, 0, 0, 3'b111, 3'b000, S_A, 3'b001, 0);
        add(0, 0, 1, 1, 3'b111, 3'b000, S_D, 3'b000, 0);

        // ---------------- reset ----------------
        step();
        step();
        check("reset_ctl", 32'(act_ctl()), 32'(exp_ctl(S_D)));
        check("reset_we", 32'(write_enb), 32'd0);
        check("reset_sr", 32'(soft_reset), 32'd0);
        check("reset_sel", 32'(fifo_full_sel), 32'd0);
        reset = 1'b0;
        pkt_valid = 1'b0;
        data_in = 2'd0;
        step();
        check("idle_ctl", 32'(act_ctl()), 32'(exp_ctl(S_D)));

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            pkt_valid = vecs[i].pv;
            data_in = vecs[i].din;
            parity_done = vecs[i].pd;
            low_pkt_valid = vecs[i].lpv;
            fifo_empty = vecs[i].fe;
            fifo_full = vecs[i].ff;
            read_enb = 3'b000;
            step();
            check($sformatf("vec%0d", i),
                  32'({act_ctl(), write_enb, fifo_full_sel, valid_out, soft_reset}),
                  32'({exp_ctl(vecs[i].st), vecs[i].we, vecs[i].sel,
                       ~vecs[i].fe, 3'b000}));
        end
        pkt_valid = 1'b0;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full = 3'b000;
        fifo_empty = 3'b111;
        step();

        // ---------------- timeout: 30 unread cycles ----------------
        fifo_empty = 3'b110;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("to_plain_c%0d", k), 32'(soft_reset),
                  (k == 30) ? 32'd1 : 32'd0);
        end
        fifo_empty = 3'b111;
        step();

        // ---------------- timeout: read at cycle 15 restarts count ----------------
        fifo_empty = 3'b110;
        for (int k = 1; k <= 47; k++) begin
            read_enb = (k == 15) ? 3'b001 : 3'b000;
            step();
            check($sformatf("to_read_c%0d", k), 32'(soft_reset),
                  (k == 45) ? 32'd1 : 32'd0);
        end
        read_enb = 3'b000;
        fifo_empty = 3'b111;
        step();

        // ---------------- timeout aborts a packet in LOAD_DATA ----------------
        pkt_valid = 1'b1;
        data_in = 2'd0;
        step();
        check("abort_lfd", 32'(act_ctl()), 32'(exp_ctl(S_F)));
        step();
        check("abort_ld", 32'(act_ctl()), 32'(exp_ctl(S_L)));
        fifo_empty = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("abort_hold_c%0d", k),
                  32'({act_ctl(), soft_reset}),
                  32'({exp_ctl(S_L), (k == 30) ? 3'b001 : 3'b000}));
        end
        step();
        check("abort_decode", 32'({act_ctl(), soft_reset}),
              32'({exp_ctl(S_D), 3'b000}));
        pkt_valid = 1'b0;
        fifo_empty = 3'b111;
        step();
        check("abort_idle", 32'(act_ctl()), 32'(exp_ctl(S_D)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
